// File: rtl/config_chain_sequencer_pkg.sv
// Shared encodings and default sizing for the configuration chain sequencer.
package cfg_seq_pkg;

  localparam int DEF_NUM_COLS   = 4;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_CHAIN_BITS = 1024;

  typedef enum logic [1:0] {
    OP_SHIFT = 2'b00,
    OP_SET   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_SET   = 2'b10
  } state_e;

endpackage

// File: rtl/config_chain_sequencer_if.sv
// Command handshake between the Wishbone front end and the chain sequencer.
interface config_chain_sequencer_if #(
  parameter int COL_W  = 2,
  parameter int WORD_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [COL_W-1:0]  cmd_col;
  logic [WORD_W-1:0] cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_col, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_col, cmd_data, output cmd_ready);
endinterface

// File: rtl/config_chain_sequencer_piso.sv
// Parallel-in serial-out word register, LSB first, with a bit index that flags the last bit.
module config_shift_piso #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [WORD_W-1:0] data_i,
  output logic              bit_o,
  output logic              last
);
  localparam int IDX_W = $clog2(WORD_W);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (load) begin
      sr_d  = data_i;
      idx_d = '0;
    end else if (step) begin
      sr_d  = sr_q >> 1;
      idx_d = idx_q + 1'b1;
    end
  end

  // Only the index is control; the word contents are gated downstream by state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign bit_o = sr_q[0];
  assign last  = (idx_q == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/config_chain_sequencer.sv
// Serialises configuration words into per-column shift chains, issues latch pulses
// and tracks per-column bit counts so software can confirm every chain is complete.
module config_chain_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int NUM_COLS   = DEF_NUM_COLS,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int COL_W      = $clog2(NUM_COLS),
  parameter int CHAIN_BITS = DEF_CHAIN_BITS,
  parameter int CNT_W      = $clog2(CHAIN_BITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  config_chain_sequencer_if.slave cmd,
  output logic                  cen,
  output logic                  cfg_data,
  output logic [NUM_COLS-1:0]   shift_out,
  output logic [NUM_COLS-1:0]   set_out,
  output logic [NUM_COLS-1:0]   col_full,
  output logic                  busy,
  output logic                  err
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CHAIN_BITS);

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [NUM_COLS-1:0] mask_q, mask_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q [NUM_COLS];
  logic [CNT_W-1:0]    cnt_d [NUM_COLS];

  logic                accept, piso_load, piso_step, piso_bit, piso_last;
  logic [NUM_COLS-1:0] col_sel, cmd_mask;

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd_mask      = cmd.cmd_data[NUM_COLS-1:0];
  assign piso_load     = accept && (op_e'(cmd.cmd_op) == OP_SHIFT);
  assign piso_step     = (state_q == ST_SHIFT);

  // An out-of-range column selects nothing, so its SHIFT strobes no chain.
  always_comb begin
    for (int i = 0; i < NUM_COLS; i++) begin
      col_sel[i]  = (int'(col_q) == i);
      col_full[i] = (cnt_q[i] == FULL);
    end
  end

  config_shift_piso #(.WORD_W(WORD_W)) u_piso (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (piso_load),
    .step   (piso_step),
    .data_i (cmd.cmd_data),
    .bit_o  (piso_bit),
    .last   (piso_last)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    mask_d  = mask_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op_e'(cmd.cmd_op))
            OP_SHIFT: begin
              state_d = ST_SHIFT;
              col_d   = cmd.cmd_col;
              if (int'(cmd.cmd_col) >= NUM_COLS) err_d = 1'b1;
            end
            OP_SET: begin
              if (cmd_mask == '0) begin
                err_d = 1'b1;
              end else begin
                state_d = ST_SET;
                mask_d  = cmd_mask;
                if ((cmd_mask & ~col_full) != '0) err_d = 1'b1;
              end
            end
            OP_CLEAR: begin
              for (int i = 0; i < NUM_COLS; i++)
                if (cmd_mask[i]) cnt_d[i] = '0;
              if (cmd.cmd_data[WORD_W-1]) err_d = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_SHIFT: begin
        // Overflowing bits are still shifted; the count saturates and err flags it.
        for (int i = 0; i < NUM_COLS; i++) begin
          if (col_sel[i]) begin
            if (col_full[i]) err_d = 1'b1;
            else             cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        if (piso_last) state_d = ST_IDLE;
      end
      ST_SET: begin
        for (int i = 0; i < NUM_COLS; i++)
          if (mask_q[i]) cnt_d[i] = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign cen       = (state_q == ST_SHIFT) || (state_q == ST_SET);
  assign cfg_data  = (state_q == ST_SHIFT) && piso_bit;
  assign shift_out = (state_q == ST_SHIFT) ? col_sel : '0;
  assign set_out   = (state_q == ST_SET)   ? mask_q  : '0;
  assign err       = err_q;

endmodule

// File: tb/tb_config_chain_sequencer.sv
// Bench for config_chain_sequencer: command table with scoreboarded strobes, plus reset and column-range sequences.
module tb_config_chain_sequencer;
  import cfg_seq_pkg::*;

  localparam int WORD_W     = 32;
  localparam int CHAIN_BITS = 1024;
  localparam int COL_W      = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  config_chain_sequencer_if #(.COL_W(COL_W), .WORD_W(WORD_W)) c4 ();
  config_chain_sequencer_if #(.COL_W(COL_W), .WORD_W(WORD_W)) c3 ();

  logic       cen4, cfg4, busy4, err4;
  logic [3:0] sh4, set4, full4;
  logic       cen3, cfg3, busy3, err3;
  logic [2:0] sh3, set3, full3;

  config_chain_sequencer #(
    .NUM_COLS(4), .WORD_W(WORD_W), .COL_W(COL_W), .CHAIN_BITS(CHAIN_BITS), .CNT_W(11)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd(c4),
    .cen(cen4), .cfg_data(cfg4), .shift_out(sh4), .set_out(set4),
    .col_full(full4), .busy(busy4), .err(err4)
  );

  config_chain_sequencer #(
    .NUM_COLS(3), .WORD_W(WORD_W), .COL_W(COL_W), .CHAIN_BITS(CHAIN_BITS), .CNT_W(11)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd(c3),
    .cen(cen3), .cfg_data(cfg3), .shift_out(sh3), .set_out(set3),
    .col_full(full3), .busy(busy3), .err(err3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected strobe beats while cen is high on dut4.
  typedef struct packed {
    logic       cfg;
    logic [3:0] sh;
    logic [3:0] st;
  } beat_t;

  beat_t sb[$];
  beat_t mon_act, mon_exp;

  always @(negedge clk) begin
    if (rst_n) begin
      mon_act = {cfg4, sh4, set4};
      if (cen4) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got beat 0x%0h, expected no activity", mon_act);
        end else begin
          mon_exp = sb.pop_front();
          check("sb_beat", mon_act, mon_exp);
        end
      end else begin
        check("idle_strobes", mon_act, 0);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [1:0] col, input logic [31:0] data,
                       output int busy_cycles);
    int guard;
    guard = 0;
    while (!c4.cmd_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    c4.cmd_valid = 1'b1;
    c4.cmd_op    = op;
    c4.cmd_col   = col;
    c4.cmd_data  = data;
    if (op == OP_SHIFT)
      for (int k = 0; k < WORD_W; k++) sb.push_back({data[k], 4'b0001 << col, 4'b0000});
    if (op == OP_SET && data[3:0] != 4'b0000)
      sb.push_back({1'b0, 4'b0000, data[3:0]});
    @(posedge clk); #1;
    c4.cmd_valid = 1'b0;
    busy_cycles = 0;
    while (!c4.cmd_ready && busy_cycles < 100) begin
      @(posedge clk); #1;
      busy_cycles++;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  col;
    logic [31:0] data;
    int          reps;
    logic        exp_err;
    logic [3:0]  exp_full;
    int          exp_busy;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int bc;
    int bad, cen_cnt, g;

    vecs[0]  = '{OP_SHIFT, 2'd2, 32'h0000_0005,  1, 1'b0, 4'b0000, 32};
    vecs[1]  = '{OP_SHIFT, 2'd0, 32'hA5A5_0F0F, 31, 1'b0, 4'b0000, 32};
    vecs[2]  = '{OP_SHIFT, 2'd0, 32'hFFFF_0000,  1, 1'b0, 4'b0001, 32};
    vecs[3]  = '{OP_SHIFT, 2'd0, 32'h0000_0001,  1, 1'b1, 4'b0001, 32};
    vecs[4]  = '{OP_CLEAR, 2'd0, 32'h8000_0000,  1, 1'b0, 4'b0001,  0};
    vecs[5]  = '{OP_SET,   2'd0, 32'h0000_0001,  1, 1'b0, 4'b0000,  1};
    vecs[6]  = '{OP_SET,   2'd0, 32'h0000_0002,  1, 1'b1, 4'b0000,  1};
    vecs[7]  = '{OP_CLEAR, 2'd0, 32'h8000_000F,  1, 1'b0, 4'b0000,  0};
    vecs[8]  = '{OP_SET,   2'd0, 32'h0000_0000,  1, 1'b1, 4'b0000,  0};
    vecs[9]  = '{OP_CLEAR, 2'd0, 32'h8000_0000,  1, 1'b0, 4'b0000,  0};
    vecs[10] = '{OP_RSVD,  2'd0, 32'h0000_0000,  1, 1'b1, 4'b0000,  0};
    vecs[11] = '{OP_CLEAR, 2'd0, 32'h8000_0000,  1, 1'b0, 4'b0000,  0};

    c4.cmd_valid = 1'b0; c4.cmd_op = 2'b00; c4.cmd_col = '0; c4.cmd_data = '0;
    c3.cmd_valid = 1'b0; c3.cmd_op = 2'b00; c3.cmd_col = '0; c3.cmd_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", c4.cmd_ready, 1'b1);
    check("reset_ctrl", {cen4, cfg4, busy4, err4}, 4'b0000);
    check("reset_strobes", {sh4, set4, full4}, 12'h000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 12; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        issue(vecs[v].op, vecs[v].col, vecs[v].data, bc);
        check($sformatf("busy_cycles[%0d]", v), bc, vecs[v].exp_busy);
      end
      check($sformatf("err[%0d]", v), err4, vecs[v].exp_err);
      check($sformatf("col_full[%0d]", v), full4, vecs[v].exp_full);
    end

    // Reset asserted at bit 10 of a SHIFT must drop everything immediately.
    c4.cmd_valid = 1'b1; c4.cmd_op = OP_SHIFT; c4.cmd_col = 2'd1; c4.cmd_data = 32'hFFFF_FFFF;
    for (int k = 0; k < WORD_W; k++) sb.push_back({1'b1, 4'b0010, 4'b0000});
    @(posedge clk); #1;
    c4.cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_shift_cen", cen4, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async_ready", c4.cmd_ready, 1'b1);
    check("rst_async_ctrl", {cen4, cfg4, busy4, err4}, 4'b0000);
    check("rst_async_strobes", {sh4, set4, full4}, 12'h000);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 32; r++) begin
      issue(OP_SHIFT, 2'd1, $urandom, bc);
      if (r == 30) check("restart_not_full_31", full4, 4'b0000);
    end
    check("restart_full_32", full4, 4'b0010);
    check("restart_err", err4, 1'b0);
    check("sb_drained", sb.size(), 0);

    // Three-column instance: reserved op and out-of-range column.
    c3.cmd_valid = 1'b1; c3.cmd_op = OP_RSVD; c3.cmd_data = '0;
    @(posedge clk); #1;
    c3.cmd_valid = 1'b0;
    check("rsvd_err", err3, 1'b1);
    check("rsvd_ready", c3.cmd_ready, 1'b1);
    c3.cmd_valid = 1'b1; c3.cmd_op = OP_CLEAR; c3.cmd_data = 32'h8000_0000;
    @(posedge clk); #1;
    c3.cmd_valid = 1'b0;
    check("clear3_err", err3, 1'b0);
    c3.cmd_valid = 1'b1; c3.cmd_op = OP_SHIFT; c3.cmd_col = 2'd3; c3.cmd_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    c3.cmd_valid = 1'b0;
    bad = 0; cen_cnt = 0; g = 0;
    while (!c3.cmd_ready && g < 100) begin
      if (sh3 != 3'b000) bad++;
      if (cen3) cen_cnt++;
      @(posedge clk); #1;
      g++;
    end
    check("col3_shift_out_zero", bad, 0);
    check("col3_cen_cycles", cen_cnt, WORD_W);
    check("col3_err", err3, 1'b1);
    check("col3_idle", {cfg3, sh3, set3, full3, busy3}, 11'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
